motion_sequencer: RTL
=====================

Name: motion_sequencer

Overview:
- Sequences the rover motor driver by producing its 8-bit motion state code (0=stop, 1=fwd fast, 2=fwd slow, 3=back fast, 4=back slow, 5=right pivot, 6=right slow, 7=left pivot, 8=left slow).
- Accepts timed motion commands over a valid/ready handshake.
- Inserts a stop dead-time whenever the motor direction class changes.
- Latches a stall fault from the current-sense comparators.
- Sits between navigation logic and the motor driver's `state` input.

Parameters:
- TICK_DIV, 100000: clock cycles per 1 ms timebase tick (100 MHz clock).
- DEADTIME_MS, 50: forced stop time, in ticks, on a direction-class change.
- STALL_MS, 200: continuous overcurrent time, in ticks, that declares a stall.
- DUR_W, 12: width of the command duration field.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  sequencer can accept a command this cycle.
- cmd_code  in  4  requested motion code, 0..8.
- cmd_dur  in  DUR_W  duration in ms; 0 = run until replaced or aborted.
- abort  in  1  immediate stop request.
- oc_left  in  1  left motor overcurrent comparator; asynchronous.
- oc_right  in  1  right motor overcurrent comparator; asynchronous.
- fault_clr  in  1  clears a latched fault.
- state  out  8  motion code to the motor driver; registered.
- busy  out  1  high in DEADTIME or RUN.
- done  out  1  one-cycle pulse when a timed command expires.
- fault  out  1  stall fault latched.

Behaviour:
- Reset values: state=0, cmd_ready=1, busy=0, done=0, fault=0. FSM=IDLE. Prescaler, duration and stall counters = 0.
- Direction class per code:
  - S: 0 and invalid codes 9..15, which are treated as code 0.
  - F: 1, 2, 6, 8.
  - B: 3, 4.
  - R: 5.
  - L: 7.
- FSM states: IDLE, DEADTIME, RUN, FAULT. Each state has a one-hot debug encoding; encoding is free.
- cmd_ready = 1 in IDLE and RUN; 0 in DEADTIME and FAULT. Accept = cmd_valid & cmd_ready at a rising edge. The code and duration are captured at that edge.
- On accept, the next state depends on the command:
  - Code S: go to IDLE; state=0 at the next edge.
  - From IDLE with a non-S code: go to RUN; state=code at the next edge (1-cycle latency).
  - From RUN, same class as the current code: stay in RUN. state=new code at the next edge; duration counter reloads; prescaler restarts.
  - From RUN, different class: go to DEADTIME; state=0 at the next edge. The pending code and duration are held. After DEADTIME_MS ticks, go to RUN with state=pending code.
- Timebase: the prescaler restarts at 0 on entry to DEADTIME or RUN. A tick occurs every TICK_DIV cycles after that. A duration of N ms in RUN lasts exactly N*TICK_DIV cycles from the first cycle state=code.
- Timed expiry (cmd_dur≠0): when the duration count reaches 0, state=0, done=1 for one cycle, go to IDLE. With cmd_dur=0 there is no expiry.
- Stall detection:
  - oc_left and oc_right each pass through a 2-FF synchronizer, then are ORed.
  - In RUN, the stall counter increments per tick while the synced OR is high, and clears to 0 on any cycle it is low.
  - Counter reaches STALL_MS: go to FAULT; state=0, fault=1.
  - The counter is cleared and frozen outside RUN.
- FAULT: state is held at 0 and commands are ignored. fault_clr goes to IDLE and fault=0, even if overcurrent persists.
- abort: from RUN or DEADTIME, go to IDLE; state=0 at the next edge; the pending command is discarded; done is not pulsed. No effect in FAULT or IDLE.
- Same-edge priority: reset > stall entry > abort > duration expiry > command accept. An accept on the expiry edge is ignored; the bench sees cmd_ready drop with that edge's transition.
- Counters saturate, never wrap. Duration is loaded from DUR_W bits, so the maximum is 4095 ms.
- Reset mid-operation: asynchronous return to the reset values, including in FAULT. The pending command is lost.

Test Plan (TICK_DIV=10, DEADTIME_MS=3, STALL_MS=4):
- Timed forward: reset, then accept code 1 with dur=5 from IDLE -> state=1 one cycle later, held 50 cycles; then state=0 with a one-cycle done pulse; cmd_ready=1.
- Same-class change: in RUN with code 2 and dur=0, accept code 6 -> state=6 at the next edge; no dead-time; busy stays 1.
- Reversal dead-time: in RUN with code 1, accept code 3 with dur=2 -> state=0 for 30 cycles with cmd_ready=0; then state=3 for 20 cycles; then done.
- Stall: in RUN with code 5, hold oc_right=1 -> fault=1 and state=0 after sync delay + 40 cycles. A cmd_valid with code 1 in FAULT is ignored. fault_clr -> IDLE, fault=0.
- Stall counter clear: toggle oc_left high 35 cycles, low 1 cycle, high 35 cycles -> no fault.
- Abort and invalid codes: abort during DEADTIME -> state=0, IDLE, no done, no later pivot. Accept code 12 -> state=0. Assert reset mid-RUN -> state=0 immediately.

Source files
------------

// File: rtl/motion_sequencer.sv
// Rover motion sequencer: accepts timed motion commands, forces a stop dead-time on
// direction-class changes, and latches a stall fault from the overcurrent comparators.
module motion_sequencer #(
  parameter int TICK_DIV    = 100000,
  parameter int DEADTIME_MS = 50,
  parameter int STALL_MS    = 200,
  parameter int DUR_W       = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_code,
  input  logic [DUR_W-1:0] cmd_dur,
  input  logic             abort,
  input  logic             oc_left,
  input  logic             oc_right,
  input  logic             fault_clr,
  output logic [7:0]       state,
  output logic             busy,
  output logic             done,
  output logic             fault
);
  localparam int PW  = $clog2(TICK_DIV + 1);
  localparam int DTW = $clog2(DEADTIME_MS + 1);
  localparam int CW  = (DUR_W > DTW) ? DUR_W : DTW;
  localparam int SW  = $clog2(STALL_MS + 1);

  typedef enum logic [3:0] {
    IDLE     = 4'b0001,
    DEADTIME = 4'b0010,
    RUN      = 4'b0100,
    FAULT    = 4'b1000
  } fsm_t;

  typedef enum logic [2:0] {C_S, C_F, C_B, C_R, C_L} dclass_t;

  function automatic logic [3:0] norm_code(input logic [3:0] c);
    return (c > 4'd8) ? 4'd0 : c;
  endfunction

  function automatic dclass_t dir_class(input logic [3:0] c);
    case (c)
      4'd1, 4'd2, 4'd6, 4'd8: return C_F;
      4'd3, 4'd4:             return C_B;
      4'd5:                   return C_R;
      4'd7:                   return C_L;
      default:                return C_S;
    endcase
  endfunction

  fsm_t             fsm;
  logic [PW-1:0]    presc;
  logic [CW-1:0]    tcnt;      // dead-time ticks in DEADTIME, remaining ms in RUN (0 = untimed)
  logic [SW-1:0]    stall_cnt;
  logic [3:0]       cur_code;
  logic [3:0]       pend_code;
  logic [DUR_W-1:0] pend_dur;
  logic [1:0]       oc_l_ff, oc_r_ff;

  logic       oc_any, tick, accept;
  logic [3:0] req_code;
  dclass_t    req_cls, cur_cls;

  assign state     = {4'h0, cur_code};
  assign cmd_ready = (fsm == IDLE) || (fsm == RUN);
  assign busy      = (fsm == DEADTIME) || (fsm == RUN);
  assign fault     = (fsm == FAULT);

  assign oc_any   = oc_l_ff[1] | oc_r_ff[1];
  assign tick     = busy && (presc == PW'(TICK_DIV - 1));
  assign accept   = cmd_valid && cmd_ready;
  assign req_code = norm_code(cmd_code);
  assign req_cls  = dir_class(req_code);
  assign cur_cls  = dir_class(cur_code);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      oc_l_ff <= '0;
      oc_r_ff <= '0;
    end else begin
      oc_l_ff <= {oc_l_ff[0], oc_left};
      oc_r_ff <= {oc_r_ff[0], oc_right};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fsm       <= IDLE;
      cur_code  <= '0;
      done      <= 1'b0;
      presc     <= '0;
      tcnt      <= '0;
      stall_cnt <= '0;
      pend_code <= '0;
      pend_dur  <= '0;
    end else begin
      done  <= 1'b0;
      // Free-running inside DEADTIME/RUN; every entry path below lands on 0.
      presc <= (busy && !tick) ? presc + PW'(1) : '0;

      if (fsm != RUN || !oc_any)
        stall_cnt <= '0;
      else if (tick && stall_cnt != SW'(STALL_MS))
        stall_cnt <= stall_cnt + SW'(1);

      unique case (fsm)
        IDLE: begin
          if (accept && req_cls != C_S) begin
            fsm       <= RUN;
            cur_code  <= req_code;
            tcnt      <= CW'(cmd_dur);
            stall_cnt <= '0;
          end
        end

        DEADTIME: begin
          if (abort) begin
            fsm  <= IDLE;
            tcnt <= '0;
          end else if (tick) begin
            if (tcnt <= CW'(1)) begin
              fsm      <= RUN;
              cur_code <= pend_code;
              tcnt     <= CW'(pend_dur);
            end else begin
              tcnt <= tcnt - CW'(1);
            end
          end
        end

        RUN: begin
          // Priority: stall > abort > expiry > accept.
          if (oc_any && tick && stall_cnt == SW'(STALL_MS - 1)) begin
            fsm       <= FAULT;
            cur_code  <= '0;
            tcnt      <= '0;
            stall_cnt <= '0;
          end else if (abort) begin
            fsm       <= IDLE;
            cur_code  <= '0;
            tcnt      <= '0;
            stall_cnt <= '0;
          end else if (tick && tcnt == CW'(1)) begin
            fsm       <= IDLE;
            cur_code  <= '0;
            tcnt      <= '0;
            stall_cnt <= '0;
            done      <= 1'b1;
          end else if (accept) begin
            if (req_cls == C_S) begin
              fsm       <= IDLE;
              cur_code  <= '0;
              tcnt      <= '0;
              stall_cnt <= '0;
            end else if (req_cls == cur_cls) begin
              cur_code <= req_code;
              tcnt     <= CW'(cmd_dur);
              presc    <= '0;
            end else begin
              fsm       <= DEADTIME;
              cur_code  <= '0;
              pend_code <= req_code;
              pend_dur  <= cmd_dur;
              tcnt      <= CW'(DEADTIME_MS);
              presc     <= '0;
              stall_cnt <= '0;
            end
          end else if (tick && tcnt != '0) begin
            tcnt <= tcnt - CW'(1);
          end
        end

        FAULT: begin
          if (fault_clr) fsm <= IDLE;
        end

        default: begin
          fsm      <= IDLE;
          cur_code <= '0;
        end
      endcase
    end
  end
endmodule
